// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_N      = 3;
    localparam int DEF_RD_LAT = 1;

    function automatic int addr_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_idx_cnt.sv
// Nested i/j/k index counter, k innermost; o_last flags the (N-1,N-1,N-1) issue.
module matmul_idx_cnt
    import matmul_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [IW-1:0] o_i,
    output logic [IW-1:0] o_j,
    output logic [IW-1:0] o_k,
    output logic          o_last
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [IW-1:0] r_k;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_adv) begin
            if (r_k == LAST) begin
                r_k <= '0;
                if (r_j == LAST) begin
                    r_j <= '0;
                    r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign o_i    = r_i;
    assign o_j    = r_j;
    assign o_k    = r_k;
    assign o_last = (r_i == LAST) && (r_j == LAST) && (r_k == LAST);

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for an N x N matrix product: issues A/B reads, aligns MAC and C-write
// strobes to the operand-buffer read latency.
//
// state    | meaning
// ST_IDLE  | waiting for start; addresses hold
// ST_RUN   | issuing one (i,j,k) read per cycle
// ST_DRAIN | reads done, waiting for the last C write to leave the pipeline
// ST_DONE  | one-cycle done pulse, then back to idle
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int AW     = addr_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          rd_en,
    output logic          mac_clr,
    output logic          mac_en,
    output logic [AW-1:0] c_addr,
    output logic          c_we
);

    localparam int IW = idx_width(N);

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_rd_en;
    logic [AW-1:0] r_a_addr;
    logic [AW-1:0] r_b_addr;
    logic [AW-1:0] r_issue_c;
    logic          r_issue_k0;
    logic          r_issue_kl;
    logic          r_issue_last;
    logic [2:0]    r_drain_cnt;

    logic [RD_LAT-1:0] r_en_pipe;
    logic [RD_LAT-1:0] r_clr_pipe;
    logic [RD_LAT-1:0] r_we_pipe;
    logic [AW-1:0]     r_caddr_pipe [RD_LAT];
    logic              r_c_we;
    logic [AW-1:0]     r_c_addr;

    logic [IW-1:0] w_i;
    logic [IW-1:0] w_j;
    logic [IW-1:0] w_k;
    logic          w_last;
    logic          w_abort;
    logic          w_issue;
    logic [AW-1:0] w_a_next;
    logic [AW-1:0] w_b_next;
    logic [AW-1:0] w_c_next;

    // abort only counts while a product is in flight, including the DONE cycle
    assign w_abort = abort && r_busy;
    assign w_issue = ((r_state == ST_IDLE) && start) ||
                     ((r_state == ST_RUN) && !abort && !r_issue_last);

    assign w_a_next = AW'(int'(w_i) * N + int'(w_k));
    assign w_b_next = AW'(int'(w_k) * N + int'(w_j));
    assign w_c_next = AW'(int'(w_i) * N + int'(w_j));

    matmul_idx_cnt #(
        .N  (N),
        .IW (IW)
    ) u_idx (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_abort),
        .i_adv  (w_issue),
        .o_i    (w_i),
        .o_j    (w_j),
        .o_k    (w_k),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_a_addr     <= '0;
            r_b_addr     <= '0;
            r_issue_c    <= '0;
            r_issue_k0   <= 1'b0;
            r_issue_kl   <= 1'b0;
            r_issue_last <= 1'b0;
            r_drain_cnt  <= '0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            if (w_issue) begin
                r_rd_en      <= 1'b1;
                r_a_addr     <= w_a_next;
                r_b_addr     <= w_b_next;
                r_issue_c    <= w_c_next;
                r_issue_k0   <= (w_k == '0);
                r_issue_kl   <= (w_k == IW'(N - 1));
                r_issue_last <= w_last;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_issue_last) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= 3'(RD_LAT);
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_drain_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // strobe pipeline: MAC strobes exit after RD_LAT, the C write one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_pipe  <= '0;
            r_clr_pipe <= '0;
            r_we_pipe  <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_caddr_pipe[s] <= '0;
            end
            r_c_we   <= 1'b0;
            r_c_addr <= '0;
        end else begin
            r_caddr_pipe[0] <= r_issue_c;
            for (int s = 1; s < RD_LAT; s++) begin
                r_caddr_pipe[s] <= r_caddr_pipe[s-1];
            end
            if (w_abort) begin
                r_en_pipe  <= '0;
                r_clr_pipe <= '0;
                r_we_pipe  <= '0;
                r_c_we     <= 1'b0;
            end else begin
                r_en_pipe[0]  <= r_rd_en;
                r_clr_pipe[0] <= r_rd_en && r_issue_k0;
                r_we_pipe[0]  <= r_rd_en && r_issue_kl;
                for (int s = 1; s < RD_LAT; s++) begin
                    r_en_pipe[s]  <= r_en_pipe[s-1];
                    r_clr_pipe[s] <= r_clr_pipe[s-1];
                    r_we_pipe[s]  <= r_we_pipe[s-1];
                end
                r_c_we <= r_we_pipe[RD_LAT-1];
                if (r_we_pipe[RD_LAT-1]) begin
                    r_c_addr <= r_caddr_pipe[RD_LAT-1];
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = r_rd_en;
    assign a_addr  = r_a_addr;
    assign b_addr  = r_b_addr;
    assign mac_en  = r_en_pipe[RD_LAT-1];
    assign mac_clr = r_clr_pipe[RD_LAT-1];
    assign c_we    = r_c_we;
    assign c_addr  = r_c_addr;

endmodule
